// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared funct3 encodings, BHT counter type and helpers
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_RESET = 2'b01;

    // Saturating 2-bit counter step: up on taken, down on not-taken.
    function automatic bht_ctr_t ctr_next(bht_ctr_t c, logic taken);
        bht_ctr_t n;
        n = c;
        if (taken && c != 2'b11) begin
            n = c + 2'b01;
        end else if (!taken && c != 2'b00) begin
            n = c - 2'b01;
        end
        return n;
    endfunction

    function automatic logic f3_illegal(logic [2:0] f3);
        return f3[2:1] == 2'b01;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - request/result handshake bundle of the branch resolve unit
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_op1;
    logic [XLEN-1:0] in_op2;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_target;
    logic            in_pred_taken;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic            out_eq;
    logic            out_lt;
    logic            out_mispredict;
    logic [XLEN-1:0] out_redirect_pc;
    logic            out_illegal;

    modport master (
        output in_valid, in_funct3, in_op1, in_op2, in_pc, in_target, in_pred_taken,
        output flush, out_ready,
        input  in_ready, out_valid, out_taken, out_eq, out_lt, out_mispredict,
        input  out_redirect_pc, out_illegal
    );

    modport slave (
        input  in_valid, in_funct3, in_op1, in_op2, in_pc, in_target, in_pred_taken,
        input  flush, out_ready,
        output in_ready, out_valid, out_taken, out_eq, out_lt, out_mispredict,
        output out_redirect_pc, out_illegal
    );
endinterface

// File: rtl/branch_resolve_unit_bht.sv
// rtl/branch_resolve_unit_bht.sv - 2-bit saturating-counter BHT, async read, sync update
module bht_2bit
    import branch_pkg::*;
#(
    parameter int BHT_DEPTH = 16,
    parameter int IW        = $clog2(BHT_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] rd_idx,
    output bht_ctr_t      rd_ctr,
    input  logic          upd_en,
    input  logic [IW-1:0] upd_idx,
    input  logic          upd_taken
);

    bht_ctr_t mem [BHT_DEPTH];

    // Read is taken from the array before this cycle's update lands.
    assign rd_ctr = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                mem[i] <= BHT_RESET;
            end
        end else if (upd_en) begin
            mem[upd_idx] <= ctr_next(mem[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch resolve: compare, redirect, BHT training, stats
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16,
    parameter int IDX_LSB   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_unit_if.slave  bus,
    input  logic [XLEN-1:0]       lookup_pc,
    output logic                  lookup_taken,
    output logic [31:0]           branch_cnt,
    output logic [31:0]           mispredict_cnt
);

    localparam int IW = $clog2(BHT_DEPTH);

    logic          capture;
    logic          consume;
    logic          eq;
    logic          lt;
    logic          taken;
    logic          illegal;
    logic [IW-1:0] held_idx;
    bht_ctr_t      lookup_ctr;
    logic          unused_lookup;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign capture      = bus.in_valid && bus.in_ready && !bus.flush;
    assign consume      = bus.out_valid && bus.out_ready;

    always_comb begin
        eq      = bus.in_op1 == bus.in_op2;
        lt      = bus.in_funct3[1] ? (bus.in_op1 < bus.in_op2)
                                   : ($signed(bus.in_op1) < $signed(bus.in_op2));
        illegal = f3_illegal(bus.in_funct3);
        taken   = 1'b0;
        case (bus.in_funct3)
            F3_BEQ:            taken = eq;
            F3_BNE:            taken = !eq;
            F3_BLT, F3_BLTU:   taken = lt;
            F3_BGE, F3_BGEU:   taken = !lt;
            default:           taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid       <= 1'b0;
            bus.out_taken       <= 1'b0;
            bus.out_eq          <= 1'b0;
            bus.out_lt          <= 1'b0;
            bus.out_mispredict  <= 1'b0;
            bus.out_redirect_pc <= '0;
            bus.out_illegal     <= 1'b0;
            held_idx            <= '0;
            branch_cnt          <= '0;
            mispredict_cnt      <= '0;
        end else begin
            if (consume) begin
                branch_cnt <= branch_cnt + 32'd1;
                if (bus.out_mispredict) begin
                    mispredict_cnt <= mispredict_cnt + 32'd1;
                end
            end
            // Flush never coincides with capture, so it only has to clear valid.
            if (capture) begin
                bus.out_valid       <= 1'b1;
                bus.out_taken       <= taken;
                bus.out_eq          <= eq;
                bus.out_lt          <= lt;
                bus.out_mispredict  <= taken != bus.in_pred_taken;
                bus.out_redirect_pc <= taken ? bus.in_target : bus.in_pc + XLEN'(4);
                bus.out_illegal     <= illegal;
                held_idx            <= bus.in_pc[IDX_LSB +: IW];
            end else if (bus.flush || consume) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

    bht_2bit #(
        .BHT_DEPTH (BHT_DEPTH),
        .IW        (IW)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (lookup_pc[IDX_LSB +: IW]),
        .rd_ctr    (lookup_ctr),
        .upd_en    (consume && !bus.out_illegal),
        .upd_idx   (held_idx),
        .upd_taken (bus.out_taken)
    );

    assign lookup_taken  = lookup_ctr[1];
    assign unused_lookup = ^{lookup_pc, lookup_ctr[0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed and randomized check of branch_resolve_unit against a behavioural model
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] lookup_pc;
    logic        lookup_taken;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(32)) bus ();

    branch_resolve_unit #(
        .XLEN      (32),
        .BHT_DEPTH (16),
        .IDX_LSB   (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .lookup_pc      (lookup_pc),
        .lookup_taken   (lookup_taken),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    typedef struct {
        logic        taken;
        logic        eq;
        logic        lt;
        logic        mis;
        logic        ill;
        logic [31:0] redir;
        int          idx;
    } rec_t;

    int          total = 0;
    int          bad   = 0;
    bit          checking = 0;
    bit          m_valid;
    rec_t        m_rec;
    logic [31:0] m_br;
    logic [31:0] m_mis;
    int          m_bht [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t resolve(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
        rec_t r;
        longint sa, sb;
        sa = a[31] ? longint'(a) - 64'sd4294967296 : longint'(a);
        sb = b[31] ? longint'(b) - 64'sd4294967296 : longint'(b);
        r.eq  = (a == b);
        r.lt  = f3[1] ? (longint'(a) < longint'(b)) : (sa < sb);
        r.ill = (f3 == 3'd2) || (f3 == 3'd3);
        case (f3)
            3'd0:       r.taken = r.eq;
            3'd1:       r.taken = !r.eq;
            3'd4, 3'd6: r.taken = r.lt;
            3'd5, 3'd7: r.taken = !r.lt;
            default:    r.taken = 1'b0;
        endcase
        r.mis   = r.taken != pred;
        r.redir = r.taken ? tgt : pc + 32'd4;
        r.idx   = int'(pc[5:2]);
        return r;
    endfunction

    always @(posedge clk) begin : model
        bit rdy, cons, cap;
        if (!rst_n) begin
            m_valid = 0;
            m_br    = 0;
            m_mis   = 0;
            for (int i = 0; i < 16; i++) m_bht[i] = 1;
        end else begin
            rdy  = !m_valid || bus.out_ready;
            cons = m_valid && bus.out_ready;
            cap  = bus.in_valid && rdy && !bus.flush;
            if (cons) begin
                m_br = m_br + 32'd1;
                if (m_rec.mis) m_mis = m_mis + 32'd1;
                if (!m_rec.ill) begin
                    if (m_rec.taken) m_bht[m_rec.idx] = (m_bht[m_rec.idx] == 3) ? 3 : m_bht[m_rec.idx] + 1;
                    else             m_bht[m_rec.idx] = (m_bht[m_rec.idx] == 0) ? 0 : m_bht[m_rec.idx] - 1;
                end
            end
            if (cap) begin
                m_valid = 1;
                m_rec   = resolve(bus.in_funct3, bus.in_op1, bus.in_op2, bus.in_pc,
                                  bus.in_target, bus.in_pred_taken);
            end else if (bus.flush || cons) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        if (checking) begin
            chk("out_valid", bus.out_valid, m_valid);
            if (m_valid) begin
                chk("out_taken", bus.out_taken, m_rec.taken);
                chk("out_eq", bus.out_eq, m_rec.eq);
                chk("out_lt", bus.out_lt, m_rec.lt);
                chk("out_mispredict", bus.out_mispredict, m_rec.mis);
                chk("out_illegal", bus.out_illegal, m_rec.ill);
                chk("out_redirect_pc", bus.out_redirect_pc, m_rec.redir);
            end
            chk("in_ready", bus.in_ready, !m_valid || bus.out_ready);
            chk("lookup_taken", lookup_taken, m_bht[lookup_pc[5:2]] >= 2);
            chk("branch_cnt", branch_cnt, m_br);
            chk("mispredict_cnt", mispredict_cnt, m_mis);
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 0;
        bus.in_valid = 0;
        bus.flush = 0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1;
    endtask

    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
        bit ok;
        int n;
        @(posedge clk); #2;
        bus.in_valid = 1;
        bus.in_funct3 = f3;
        bus.in_op1 = a;
        bus.in_op2 = b;
        bus.in_pc = pc;
        bus.in_target = tgt;
        bus.in_pred_taken = pred;
        ok = 0;
        n = 0;
        while (!ok && n < 20) begin
            ok = bus.in_ready;
            @(posedge clk);
            n++;
        end
        #2;
        bus.in_valid = 0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=no_accept required=accept");
        end
    endtask

    logic [31:0] held_cnt;
    logic [31:0] vals [5];
    bit          exp_lk [5];

    initial begin
        rst_n = 0;
        lookup_pc = 0;
        bus.in_valid = 0; bus.flush = 0; bus.out_ready = 1;
        bus.in_funct3 = 0; bus.in_op1 = 0; bus.in_op2 = 0;
        bus.in_pc = 0; bus.in_target = 0; bus.in_pred_taken = 0;

        // 1 reset
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1;
        checking = 1;
        @(negedge clk);
        chk("t1_out_valid", bus.out_valid, 0);
        chk("t1_branch_cnt", branch_cnt, 0);
        chk("t1_mispredict_cnt", mispredict_cnt, 0);
        for (int i = 0; i < 16; i++) begin
            lookup_pc = i * 4;
            #0.5;
            chk("t1_lookup", lookup_taken, 0);
        end
        lookup_pc = 32'h40;

        // 2 signed vs unsigned
        send(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h300, 1);
        @(negedge clk);
        chk("t2_blt_taken", bus.out_taken, 1);
        chk("t2_blt_lt", bus.out_lt, 1);
        send(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h300, 0);
        @(negedge clk);
        chk("t2_bltu_taken", bus.out_taken, 0);
        chk("t2_bltu_lt", bus.out_lt, 0);
        send(3'b111, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h300, 1);
        @(negedge clk);
        chk("t2_bgeu_taken", bus.out_taken, 1);
        chk("t2_bgeu_lt", bus.out_lt, 0);

        // 3 redirect
        send(3'b000, 32'd5, 32'd5, 32'h100, 32'h80, 0);
        @(negedge clk);
        chk("t3_beq_taken", bus.out_taken, 1);
        chk("t3_beq_mis", bus.out_mispredict, 1);
        chk("t3_beq_redir", bus.out_redirect_pc, 32'h80);
        @(posedge clk); @(negedge clk);
        chk("t3_mis_cnt", mispredict_cnt, 1);
        send(3'b001, 32'd5, 32'd5, 32'h100, 32'h80, 0);
        @(negedge clk);
        chk("t3_bne_redir", bus.out_redirect_pc, 32'h104);
        send(3'b001, 32'd5, 32'd5, 32'hFFFF_FFFC, 32'h80, 0);
        @(negedge clk);
        chk("t3_wrap_redir", bus.out_redirect_pc, 32'h0);

        // 4 backpressure then flush
        @(posedge clk); #2;
        bus.out_ready = 0;
        send(3'b000, 32'd7, 32'd7, 32'h10, 32'h20, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", bus.out_valid, 1);
            chk("t4_in_ready", bus.in_ready, 0);
            chk("t4_hold_redir", bus.out_redirect_pc, 32'h20);
            chk("t4_hold_taken", bus.out_taken, 1);
        end
        held_cnt = branch_cnt;
        @(posedge clk); #2;
        bus.flush = 1;
        bus.in_valid = 1;
        bus.in_funct3 = 3'b001;
        @(posedge clk); #2;
        bus.flush = 0;
        bus.in_valid = 0;
        @(negedge clk);
        chk("t4_flush_valid", bus.out_valid, 0);
        chk("t4_flush_cnt", branch_cnt, held_cnt);
        @(negedge clk);
        chk("t4_no_capture", bus.out_valid, 0);
        bus.out_ready = 1;

        // 5 BHT training with aliasing
        do_reset();
        lookup_pc = 32'h40;
        @(negedge clk);
        chk("t5_lookup_init", lookup_taken, 0);
        exp_lk = '{1, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) send(3'b000, 32'd1, 32'd1, 32'h40, 32'h0, 0);
            else       send(3'b001, 32'd1, 32'd1, 32'h80, 32'h0, 0);
            @(posedge clk); @(negedge clk);
            chk("t5_lookup", lookup_taken, exp_lk[i]);
        end

        // 6 illegal funct3 leaves BHT alone; counter wrap
        send(3'b000, 32'd1, 32'd1, 32'h40, 32'h0, 1);
        @(posedge clk); @(negedge clk);
        chk("t6_lookup_pre", lookup_taken, 1);
        send(3'b010, 32'd1, 32'd1, 32'h40, 32'h0, 1);
        @(negedge clk);
        chk("t6_ill_taken", bus.out_taken, 0);
        chk("t6_ill_flag", bus.out_illegal, 1);
        chk("t6_ill_mis", bus.out_mispredict, 1);
        @(posedge clk); @(negedge clk);
        chk("t6_lookup_post", lookup_taken, 1);
        @(posedge clk); #2;
        force dut.branch_cnt = 32'hFFFF_FFFF;
        m_br = 32'hFFFF_FFFF;
        #1;
        release dut.branch_cnt;
        send(3'b000, 32'd3, 32'd4, 32'h44, 32'h0, 0);
        @(posedge clk); @(negedge clk);
        chk("t6_cnt_wrap", branch_cnt, 0);

        // randomized traffic
        vals = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1};
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #2;
            rst_n             = ($urandom_range(0, 599) != 0);
            bus.in_valid      = ($urandom_range(0, 3) != 0);
            bus.out_ready     = ($urandom_range(0, 3) != 0);
            bus.flush         = ($urandom_range(0, 15) == 0);
            bus.in_funct3     = 3'($urandom_range(0, 7));
            bus.in_op1        = ($urandom_range(0, 1) == 0) ? $urandom : vals[$urandom_range(0, 4)];
            bus.in_op2        = ($urandom_range(0, 3) == 0) ? bus.in_op1 :
                                (($urandom_range(0, 1) == 0) ? $urandom : vals[$urandom_range(0, 4)]);
            bus.in_pc         = {$urandom_range(0, 255), 2'b00};
            if ($urandom_range(0, 15) == 0) bus.in_pc = 32'hFFFF_FFFC;
            bus.in_target     = $urandom;
            bus.in_pred_taken = 1'($urandom_range(0, 1));
            lookup_pc         = {$urandom_range(0, 255), 2'b00};
        end
        @(posedge clk); #2;
        rst_n = 1;
        bus.in_valid = 0;
        bus.flush = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
